// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-granular memory-to-memory copy engine.
//
// Acts as a bus initiator on the CPU-style memory interface. Each word is
// moved as one read transaction followed by one write transaction, with one
// idle cycle after each. Firmware programs SRC/DST/LEN and starts the copy
// through a simple core register port.
//
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   cs, we, address,
//   write_data, read_data,
//   ready                  - register port (ready one cycle after cs,
//                            read_data registered alongside it)
//   mem_valid, mem_instr,
//   mem_addr, mem_wdata,
//   mem_wstrb, mem_rdata,
//   mem_ready              - memory initiator port (wstrb 0 = read, f = write)
//   busy                   - copy in progress, for the bus arbiter
//
// Register map (word addresses):
//   0x08 CTRL   (wo) bit0 START, bit1 ABORT
//   0x09 STATUS (ro) bit0 busy, bit1 done, bit2 aborted
//   0x10 SRC, 0x11 DST, 0x12 LEN, 0x13 COUNT (ro, words completed)
module mem_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_SRC    = 8'h10;
    localparam logic [7:0] ADDR_DST    = 8'h11;
    localparam logic [7:0] ADDR_LEN    = 8'h12;
    localparam logic [7:0] ADDR_COUNT  = 8'h13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP1,
        S_WR,
        S_GAP2,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [31:0]            src_cur_q, src_cur_d;
    logic [31:0]            dst_cur_q, dst_cur_d;
    logic [31:0]            buf_q, buf_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   ready_q, ready_d;
    logic [31:0]            read_data_q, read_data_d;

    logic busy_w;
    logic reg_wr;
    logic reg_rd;
    logic ctrl_start;
    logic ctrl_abort;

    // DONE is deliberately not busy: the flag drops as soon as the last
    // transaction has retired.
    assign busy_w     = (state_q == S_RD) || (state_q == S_GAP1) ||
                        (state_q == S_WR) || (state_q == S_GAP2);
    assign reg_wr     = cs && we;
    assign reg_rd     = cs && !we;
    assign ctrl_start = reg_wr && (address == ADDR_CTRL) && write_data[0];
    assign ctrl_abort = reg_wr && (address == ADDR_CTRL) && write_data[1];

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        count_d      = count_q;
        remaining_d  = remaining_q;
        src_cur_d    = src_cur_q;
        dst_cur_d    = dst_cur_q;
        buf_d        = buf_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        ready_d      = cs;
        read_data_d  = 32'd0;

        // Configuration writes are frozen while a copy is running.
        if (reg_wr && !busy_w) begin
            case (address)
                ADDR_SRC: src_d = {write_data[31:2], 2'b00};
                ADDR_DST: dst_d = {write_data[31:2], 2'b00};
                ADDR_LEN: len_d = write_data[LEN_WIDTH-1:0];
                default:  ;
            endcase
        end

        if (reg_rd) begin
            case (address)
                ADDR_STATUS: read_data_d = {29'd0, aborted_q, done_q, busy_w};
                ADDR_SRC:    read_data_d = src_q;
                ADDR_DST:    read_data_d = dst_q;
                ADDR_LEN:    read_data_d = 32'(len_q);
                ADDR_COUNT:  read_data_d = 32'(count_q);
                default:     read_data_d = 32'd0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // START is only honoured here; a zero-length request
                // completes immediately without touching the bus.
                if (ctrl_start) begin
                    done_d       = 1'b0;
                    aborted_d    = 1'b0;
                    count_d      = '0;
                    abort_pend_d = 1'b0;
                    if (len_q != '0) begin
                        src_cur_d   = src_q;
                        dst_cur_d   = dst_q;
                        remaining_d = len_q;
                        state_d     = S_RD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (mem_ready) begin
                    buf_d   = mem_rdata;
                    state_d = S_GAP1;
                end
            end
            S_GAP1: begin
                // A pending abort discards the word just read.
                state_d = abort_pend_q ? S_DONE : S_WR;
            end
            S_WR: begin
                if (mem_ready) begin
                    src_cur_d   = src_cur_q + 32'd4;
                    dst_cur_d   = dst_cur_q + 32'd4;
                    remaining_d = remaining_q - 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    state_d = S_GAP2;
                end
            end
            S_GAP2: begin
                state_d = ((remaining_q != '0) && !abort_pend_q) ? S_RD : S_DONE;
            end
            S_DONE: begin
                if (abort_pend_q) begin
                    aborted_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The in-flight handshake always completes; the flag is acted on at
        // the next gap state.
        if (ctrl_abort && busy_w) begin
            abort_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= 32'd0;
            dst_q        <= 32'd0;
            len_q        <= '0;
            count_q      <= '0;
            remaining_q  <= '0;
            src_cur_q    <= 32'd0;
            dst_cur_q    <= 32'd0;
            buf_q        <= 32'd0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            read_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            count_q      <= count_d;
            remaining_q  <= remaining_d;
            src_cur_q    <= src_cur_d;
            dst_cur_q    <= dst_cur_d;
            buf_q        <= buf_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            ready_q      <= ready_d;
            read_data_q  <= read_data_d;
        end
    end

    // Bus outputs decode straight from the state register, so they are
    // inherently stable while a transaction waits for mem_ready.
    assign mem_valid = (state_q == S_RD) || (state_q == S_WR);
    assign mem_instr = 1'b0;
    assign mem_wstrb = (state_q == S_WR) ? 4'hf : 4'h0;
    assign mem_addr  = (state_q == S_RD) ? src_cur_q :
                       (state_q == S_WR) ? dst_cur_q : 32'd0;
    assign mem_wdata = (state_q == S_WR) ? buf_q : 32'd0;
    assign busy      = busy_w;
    assign ready     = ready_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma. Stimulus pushes expected bus
// transactions and register read values into queues; a monitor on the
// falling edge pops and compares whenever the DUT completes a handshake or
// acknowledges a register access. The responder returns read data
// {addr[15:0], ~addr[15:0]}; expected values below are written out by hand.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    always #5 clk = ~clk;

    mem_copy_dma #(.LEN_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } reg_t;

    bus_t bus_exp[$];
    reg_t reg_exp[$];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int valid_cycles = 0;
    int wr_stall = 0;
    int vcnt = 0;

    logic        prev_wait = 1'b0;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    // Responder: raises mem_ready in the second valid cycle (plus an optional
    // stall on the next write), drops it right after the handshake edge.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ready = 1'b0;
                mem_rdata = 32'd0;
                vcnt      = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = 32'd0;
                vcnt      = 0;
            end else if (mem_valid) begin
                vcnt++;
                if (vcnt >= 2 + ((mem_wstrb != 4'h0) ? wr_stall : 0)) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'h0) begin
                        mem_rdata = {mem_addr[15:0], ~mem_addr[15:0]};
                    end else begin
                        wr_stall = 0;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            if (mem_valid) valid_cycles++;
            if (mem_valid && prev_wait) begin
                checks++;
                if (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb) begin
                    errors++;
                    $display("FAIL bus_stable: got addr=%h wdata=%h wstrb=%h required addr=%h wdata=%h wstrb=%h",
                             mem_addr, mem_wdata, mem_wstrb, p_addr, p_wdata, p_wstrb);
                end
            end
            prev_wait = mem_valid && !mem_ready;
            p_addr    = mem_addr;
            p_wdata   = mem_wdata;
            p_wstrb   = mem_wstrb;

            if (mem_valid && mem_ready) begin
                hs_cnt++;
                checks++;
                if (bus_exp.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got addr=%h wstrb=%h wdata=%h required no transaction",
                             mem_addr, mem_wstrb, mem_wdata);
                end else begin
                    bus_t e;
                    e = bus_exp.pop_front();
                    if (mem_addr !== e.addr || mem_wstrb !== e.wstrb ||
                        (e.wstrb != 4'h0 && mem_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL bus_txn: got addr=%h wstrb=%h wdata=%h required addr=%h wstrb=%h wdata=%h",
                                 mem_addr, mem_wstrb, mem_wdata, e.addr, e.wstrb, e.data);
                    end
                end
            end

            if (ready) begin
                if (reg_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reg_unexpected_ready: got ready=1 required 0");
                end else begin
                    reg_t r;
                    r = reg_exp.pop_front();
                    if (r.chk) begin
                        checks++;
                        if (read_data !== r.val) begin
                            errors++;
                            $display("FAIL %s: got %h required %h", r.name, read_data, r.val);
                        end else begin
                            $display("reg %s read %h ok", r.name, read_data);
                        end
                    end
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus_t e;
        e.addr  = a;
        e.wstrb = s;
        e.data  = d;
        bus_exp.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the access.
    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        reg_t r;
        r.chk  = 1'b0;
        r.val  = 32'd0;
        r.name = "write";
        reg_exp.push_back(r);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        reg_t r;
        r.chk  = 1'b1;
        r.val  = exp;
        r.name = name;
        reg_exp.push_back(r);
        cs = 1'b1; we = 1'b0; address = a; write_data = 32'd0;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Counts busy cycles, then lets the DONE state retire.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: got busy=1 after %0d cycles required 0", cyc);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        reg_write(8'h10, s);
        reg_write(8'h11, d);
        reg_write(8'h12, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int n;
        int base;
        reset = 1'b1; cs = 1'b0; we = 1'b0; address = 8'd0; write_data = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reg_read(8'h10, 32'd0, "reset_src");
        reg_read(8'h12, 32'd0, "reset_len");
        reg_read(8'h09, 32'd0, "reset_status");

        // Basic 3-word copy.
        setup(32'h4000_0000, 32'h4000_1000, 32'd3);
        push_bus(32'h4000_0000, 4'h0, 32'h0);
        push_bus(32'h4000_1000, 4'hf, 32'h0000_FFFF);
        push_bus(32'h4000_0004, 4'h0, 32'h0);
        push_bus(32'h4000_1004, 4'hf, 32'h0004_FFFB);
        push_bus(32'h4000_0008, 4'h0, 32'h0);
        push_bus(32'h4000_1008, 4'hf, 32'h0008_FFF7);
        reg_write(8'h08, 32'h1);
        wait_done(cyc);
        check_eq("basic_busy_cycles", cyc, 32'd18);
        check_eq("basic_bus_left", bus_exp.size(), 32'd0);
        reg_read(8'h13, 32'd3, "basic_count");
        reg_read(8'h09, 32'h2, "basic_status");
        reg_read(8'h11, 32'h4000_1000, "basic_dst");

        // Write stall of 5 cycles on the first write.
        setup(32'h0000_0100, 32'h0000_0200, 32'd2);
        push_bus(32'h0000_0100, 4'h0, 32'h0);
        push_bus(32'h0000_0200, 4'hf, 32'h0100_FEFF);
        push_bus(32'h0000_0104, 4'h0, 32'h0);
        push_bus(32'h0000_0204, 4'hf, 32'h0104_FEFB);
        wr_stall = 5;
        reg_write(8'h08, 32'h1);
        wait_done(cyc);
        check_eq("stall_busy_cycles", cyc, 32'd17);
        check_eq("stall_bus_left", bus_exp.size(), 32'd0);
        reg_read(8'h13, 32'd2, "stall_count");

        // Abort during the 4th word's read.
        setup(32'h0000_1000, 32'h0000_2000, 32'd10);
        push_bus(32'h0000_1000, 4'h0, 32'h0);
        push_bus(32'h0000_2000, 4'hf, 32'h1000_EFFF);
        push_bus(32'h0000_1004, 4'h0, 32'h0);
        push_bus(32'h0000_2004, 4'hf, 32'h1004_EFFB);
        push_bus(32'h0000_1008, 4'h0, 32'h0);
        push_bus(32'h0000_2008, 4'hf, 32'h1008_EFF7);
        push_bus(32'h0000_100C, 4'h0, 32'h0);
        base = hs_cnt;
        reg_write(8'h08, 32'h1);
        n = 0;
        while (!((hs_cnt - base) >= 6 && mem_valid && mem_wstrb == 4'h0) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check_eq("abort_reached_rd4", {31'd0, (n < 500)}, 32'd1);
        reg_write(8'h08, 32'h2);
        wait_done(cyc);
        check_eq("abort_bus_left", bus_exp.size(), 32'd0);
        reg_read(8'h13, 32'd3, "abort_count");
        reg_read(8'h09, 32'h4, "abort_status");

        // Zero-length start.
        reg_write(8'h12, 32'd0);
        base = valid_cycles;
        reg_write(8'h08, 32'h1);
        reg_read(8'h09, 32'h2, "len0_status");
        repeat (3) @(negedge clk);
        check_eq("len0_no_valid", valid_cycles - base, 32'd0);

        // Address wrap and SRC low-bit masking.
        setup(32'hFFFF_FFFF, 32'h0000_3000, 32'd2);
        reg_read(8'h10, 32'hFFFF_FFFC, "wrap_src_mask");
        push_bus(32'hFFFF_FFFC, 4'h0, 32'h0);
        push_bus(32'h0000_3000, 4'hf, 32'hFFFC_0003);
        push_bus(32'h0000_0000, 4'h0, 32'h0);
        push_bus(32'h0000_3004, 4'hf, 32'h0000_FFFF);
        reg_write(8'h08, 32'h1);
        wait_done(cyc);
        check_eq("wrap_bus_left", bus_exp.size(), 32'd0);
        reg_read(8'h13, 32'd2, "wrap_count");

        // Reset during a write stall, then a normal run.
        setup(32'h0000_0500, 32'h0000_0600, 32'd4);
        push_bus(32'h0000_0500, 4'h0, 32'h0);
        wr_stall = 50;
        reg_write(8'h08, 32'h1);
        n = 0;
        while (!(mem_valid && mem_wstrb == 4'hf) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check_eq("rst_reached_wr", {31'd0, (n < 500)}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wr_stall = 0;
        reg_read(8'h10, 32'd0, "rst_src");
        reg_read(8'h11, 32'd0, "rst_dst");
        reg_read(8'h12, 32'd0, "rst_len");
        reg_read(8'h13, 32'd0, "rst_count");
        reg_read(8'h09, 32'd0, "rst_status");
        check_eq("rst_bus_left", bus_exp.size(), 32'd0);
        setup(32'h0000_0700, 32'h0000_0800, 32'd1);
        push_bus(32'h0000_0700, 4'h0, 32'h0);
        push_bus(32'h0000_0800, 4'hf, 32'h0700_F8FF);
        reg_write(8'h08, 32'h1);
        wait_done(cyc);
        check_eq("post_rst_busy_cycles", cyc, 32'd6);
        check_eq("post_rst_bus_left", bus_exp.size(), 32'd0);
        reg_read(8'h13, 32'd1, "post_rst_count");
        reg_read(8'h09, 32'h2, "post_rst_status");
        repeat (2) @(negedge clk);
        check_eq("reg_queue_left", reg_exp.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
